// File: rtl/syn_ram_pkg.sv
// Shared types and helpers for the syn_ram_dp dual-port RAM family.
package syn_ram_pkg;

  typedef enum logic {
    RDW_OLD = 1'b0,
    RDW_NEW = 1'b1
  } rdw_mode_e;

  typedef enum logic {
    IDLE,
    CLEAR
  } clr_state_e;

  localparam int unsigned MAX_LANE_W = 64;

  // Even-parity bit for one lane; callers zero-extend narrower lanes to MAX_LANE_W.
  function automatic logic lane_parity(input logic [MAX_LANE_W-1:0] lane);
    return ^lane;
  endfunction

endpackage

// File: rtl/syn_ram_clr_ctrl.sv
// Array clear engine: walks every address once, one per cycle, while busy is high.
module syn_ram_clr_ctrl
  import syn_ram_pkg::*;
#(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == '1) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == CLEAR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign clr_we   = busy_q;
  assign clr_addr = cnt_q;

endmodule

// File: rtl/syn_ram_dp.sv
// Simple dual-port synchronous RAM with lane enables, RD_LAT 1/2, RDW select and clear engine.
// Optional per-lane even parity storage and checking: define SYN_RAM_DP_PARITY_EN.
module syn_ram_dp
  import syn_ram_pkg::*;
#(
  parameter  int unsigned DATA_W    = 8,
  parameter  int unsigned LANE_W    = 4,
  parameter  int unsigned ADDR_W    = 4,
  parameter  int unsigned RD_LAT    = 1,
  parameter  int unsigned RDW_MODE  = 0,
  localparam int unsigned NUM_LANES = DATA_W / LANE_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic [NUM_LANES-1:0] wr_be,
  input  logic                 re,
  input  logic [ADDR_W-1:0]    rd_addr,
  input  logic                 oe,
  output logic [DATA_W-1:0]    dout,
  output logic                 rd_valid,
  input  logic                 clr_req,
  output logic                 busy,
  output logic                 par_err
);

  localparam int unsigned DEPTH   = 2 ** ADDR_W;
  localparam rdw_mode_e   RDW_SEL = (RDW_MODE != 0) ? RDW_NEW : RDW_OLD;

  logic                 clr_we;
  logic [ADDR_W-1:0]    clr_addr;
  logic                 wr_fire, rd_fire;
  logic [NUM_LANES-1:0] mem_lane_we;
  logic [ADDR_W-1:0]    mem_waddr;
  logic [DATA_W-1:0]    mem_wdata;
  logic [DATA_W-1:0]    rd_word;
  logic                 rd_perr;
  logic                 pipe_valid;
  logic [DATA_W-1:0]    pipe_data;
  logic                 pipe_perr;
  logic [DATA_W-1:0]    dout_reg_q, dout_reg_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 par_err_q, par_err_d;

  logic [DATA_W-1:0]    mem_q [DEPTH];
`ifdef SYN_RAM_DP_PARITY_EN
  logic [NUM_LANES-1:0] par_q [DEPTH];
  logic [NUM_LANES-1:0] rd_par;
`endif

  syn_ram_clr_ctrl #(
    .ADDR_W(ADDR_W)
  ) u_clr_ctrl (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_req (clr_req),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_addr(clr_addr)
  );

  assign wr_fire = we & ~busy;
  assign rd_fire = re & ~busy;

  // Clear owns the write port while busy; user writes are ignored then.
  always_comb begin
    mem_lane_we = '0;
    mem_waddr   = wr_addr;
    mem_wdata   = wr_data;
    if (clr_we) begin
      mem_lane_we = '1;
      mem_waddr   = clr_addr;
      mem_wdata   = '0;
    end else if (wr_fire) begin
      mem_lane_we = wr_be;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (mem_lane_we[i]) begin
        mem_q[mem_waddr][i*LANE_W +: LANE_W] <= mem_wdata[i*LANE_W +: LANE_W];
`ifdef SYN_RAM_DP_PARITY_EN
        par_q[mem_waddr][i] <= lane_parity(MAX_LANE_W'(mem_wdata[i*LANE_W +: LANE_W]));
`endif
      end
    end
  end

  // Array read sees pre-write contents; new-data mode merges the enabled write lanes on top.
  always_comb begin
    rd_word = mem_q[rd_addr];
    rd_perr = 1'b0;
`ifdef SYN_RAM_DP_PARITY_EN
    rd_par  = par_q[rd_addr];
`endif
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if ((RDW_SEL == RDW_NEW) && wr_fire && (wr_addr == rd_addr) && wr_be[i]) begin
        rd_word[i*LANE_W +: LANE_W] = wr_data[i*LANE_W +: LANE_W];
`ifdef SYN_RAM_DP_PARITY_EN
        rd_par[i] = lane_parity(MAX_LANE_W'(wr_data[i*LANE_W +: LANE_W]));
`endif
      end
    end
`ifdef SYN_RAM_DP_PARITY_EN
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (lane_parity(MAX_LANE_W'(rd_word[i*LANE_W +: LANE_W])) != rd_par[i]) begin
        rd_perr = 1'b1;
      end
    end
`endif
  end

  if (RD_LAT == 2) begin : g_lat2
    logic              s1_valid_q;
    logic [DATA_W-1:0] s1_data_q;
    logic              s1_perr_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        s1_valid_q <= 1'b0;
        s1_data_q  <= '0;
        s1_perr_q  <= 1'b0;
      end else begin
        s1_valid_q <= rd_fire;
        s1_perr_q  <= rd_fire & rd_perr;
        if (rd_fire) begin
          s1_data_q <= rd_word;
        end
      end
    end

    assign pipe_valid = s1_valid_q;
    assign pipe_data  = s1_data_q;
    assign pipe_perr  = s1_perr_q;
  end else begin : g_lat1
    assign pipe_valid = rd_fire;
    assign pipe_data  = rd_word;
    assign pipe_perr  = rd_perr;
  end

  always_comb begin
    dout_reg_d = pipe_valid ? pipe_data : dout_reg_q;
    rd_valid_d = pipe_valid;
    par_err_d  = pipe_valid & pipe_perr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_reg_q <= '0;
      rd_valid_q <= 1'b0;
      par_err_q  <= 1'b0;
    end else begin
      dout_reg_q <= dout_reg_d;
      rd_valid_q <= rd_valid_d;
      par_err_q  <= par_err_d;
    end
  end

  assign dout     = oe ? dout_reg_q : '0;
  assign rd_valid = rd_valid_q;
  assign par_err  = par_err_q;

endmodule
